// File: rtl/mmio_bridge_pkg.sv
// Shared definitions for the CPU memory-bus bridge: I/O register addresses,
// the region-decode predicate and the read-return source select.
package mmio_bridge_pkg;

    localparam logic [17:0] IO_UART_ADDR = 18'h30000;
    localparam logic [17:0] IO_CLK_ADDR  = 18'h30004;

    // Source of the byte returned on cpu_din in the cycle after a read.
    typedef enum logic [2:0] {
        SRC_RAM  = 3'd0,
        SRC_RX   = 3'd1,
        SRC_CNT0 = 3'd2,
        SRC_CNT1 = 3'd3,
        SRC_CNT2 = 3'd4,
        SRC_CNT3 = 3'd5,
        SRC_ZERO = 3'd6
    } rd_src_e;

    // The top quarter of the decoded 18-bit space is I/O; everything else is RAM.
    function automatic logic is_io(input logic [17:0] addr);
        return addr[17:16] == 2'b11;
    endfunction

endpackage

// File: rtl/mmio_bridge_sync_fifo.sv
// Single-clock FIFO with occupancy count. A push into a full FIFO is
// accepted when a pop happens in the same cycle; otherwise it is dropped and
// flagged on overflow_o for that cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [$clog2(DEPTH):0]   count_next_o,
    output logic                     overflow_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o      = (count_q == '0);
    assign full_o       = (count_q == (AW+1)'(DEPTH));
    assign do_pop       = pop_i & ~empty_o;
    assign do_push      = push_i & (~full_o | do_pop);
    assign overflow_o   = push_i & full_o & ~do_pop;
    assign data_o       = mem_q[rd_ptr_q];
    assign count_o      = count_q;
    assign count_next_o = count_d;

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
        else if (do_pop && !do_push) count_d = count_q - (AW+1)'(1);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/mmio_bridge.sv
// Bridge between the core's byte-wide memory port and RAM / UART endpoints.
// RAM accesses pass straight through; 0x30000 is the UART data register and
// 0x30004..7 the clock counter (write 0x30004 = program stop). Read data is
// returned on cpu_din exactly one cycle after the request.
//
// TX stream handshake: tx_data is stable and meaningful whenever tx_valid is
// high; a byte transfers on every rising clk_in where tx_valid and tx_ready
// are both high. tx_valid never depends combinationally on tx_ready.
module mmio_bridge
    import mmio_bridge_pkg::*;
#(
    parameter int RAM_ADDR_W  = 17,
    parameter int TX_DEPTH    = 16,
    parameter int FULL_MARGIN = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic [31:0]           cpu_a,
    input  logic [7:0]            cpu_dout,
    input  logic                  cpu_wr,
    output logic [7:0]            cpu_din,
    output logic                  io_buffer_full,
    output logic [RAM_ADDR_W-1:0] ram_a,
    output logic [7:0]            ram_dout,
    output logic                  ram_we,
    input  logic [7:0]            ram_din,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_pop,
    output logic                  prog_done,
    output logic                  tx_overflow
);

    localparam int AW = $clog2(TX_DEPTH);

    logic [17:0]  addr;
    logic         io_sel, acc, wr_acc, rd_acc;
    logic         uart_hit, clk_hit, cnt_hit;
    logic         push, fifo_empty, fifo_full, fifo_ovf, tx_pop;
    logic [7:0]   push_data, fifo_head;
    logic [AW:0]  fifo_count, fifo_count_next;
    logic         unused_ok;

    logic [31:0]  cnt_q, snap_q, snap_d;
    logic [7:0]   rx_q, rx_d, hold_q;
    rd_src_e      src_q, src_d;
    logic         pend_q, full_q, full_d;
    logic         prog_done_q, prog_done_d, ovf_q, ovf_d;

    // Address decode and access qualification; nothing counts during reset.
    assign addr     = cpu_a[17:0];
    assign io_sel   = is_io(addr);
    assign acc      = rdy_in & ~rst_in;
    assign wr_acc   = acc & cpu_wr;
    assign rd_acc   = acc & ~cpu_wr;
    assign uart_hit = io_sel & (addr == IO_UART_ADDR);
    assign clk_hit  = io_sel & (addr == IO_CLK_ADDR);
    assign cnt_hit  = io_sel & (addr[17:2] == IO_CLK_ADDR[17:2]);

    // RAM pass-through.
    assign ram_a    = cpu_a[RAM_ADDR_W-1:0];
    assign ram_dout = cpu_dout;
    assign ram_we   = wr_acc & ~io_sel;

    // UART side: 0x00 written to the data register is not a character;
    // the stop register pushes a 0x00 terminator instead.
    assign push      = wr_acc & ((uart_hit & (cpu_dout != 8'h00)) | clk_hit);
    assign push_data = clk_hit ? 8'h00 : cpu_dout;
    assign rx_pop    = rd_acc & uart_hit & rx_valid;
    assign tx_pop    = tx_valid & tx_ready;
    assign tx_valid  = ~fifo_empty;
    assign tx_data   = fifo_empty ? 8'h00 : fifo_head;

    assign unused_ok = ^{cpu_a[31:18], fifo_count, fifo_full};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk_i        (clk_in),
        .rst_i        (rst_in),
        .push_i       (push),
        .data_i       (push_data),
        .pop_i        (tx_pop),
        .data_o       (fifo_head),
        .empty_o      (fifo_empty),
        .full_o       (fifo_full),
        .count_o      (fifo_count),
        .count_next_o (fifo_count_next),
        .overflow_o   (fifo_ovf)
    );

    // Read-source select and snapshot/RX latch next-state for this request.
    always_comb begin
        src_d  = SRC_ZERO;
        snap_d = snap_q;
        rx_d   = rx_q;
        if (!io_sel) begin
            src_d = SRC_RAM;
        end else if (uart_hit && rx_valid) begin
            src_d = SRC_RX;
            rx_d  = rx_data;
        end else if (cnt_hit) begin
            case (addr[1:0])
                2'd0:    src_d = SRC_CNT0;
                2'd1:    src_d = SRC_CNT1;
                2'd2:    src_d = SRC_CNT2;
                default: src_d = SRC_CNT3;
            endcase
        end
        if (!rd_acc) begin
            src_d  = src_q;
            rx_d   = rx_q;
        end else if (clk_hit) begin
            snap_d = cnt_q;
        end
    end

    // Sticky flags and the near-full indication seen by the core.
    always_comb begin
        prog_done_d = prog_done_q | (wr_acc & clk_hit);
        ovf_d       = ovf_q | fifo_ovf;
        full_d      = (TX_DEPTH - int'(fifo_count_next)) <= FULL_MARGIN;
    end

    // Return mux: fresh data the cycle after a read, otherwise hold.
    always_comb begin
        cpu_din = hold_q;
        if (pend_q) begin
            case (src_q)
                SRC_RAM:  cpu_din = ram_din;
                SRC_RX:   cpu_din = rx_q;
                SRC_CNT0: cpu_din = snap_q[7:0];
                SRC_CNT1: cpu_din = snap_q[15:8];
                SRC_CNT2: cpu_din = snap_q[23:16];
                SRC_CNT3: cpu_din = snap_q[31:24];
                default:  cpu_din = 8'h00;
            endcase
        end
    end

    // Bridge state registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_q       <= '0;
            snap_q      <= '0;
            rx_q        <= '0;
            hold_q      <= '0;
            src_q       <= SRC_ZERO;
            pend_q      <= 1'b0;
            full_q      <= 1'b0;
            prog_done_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_q + 32'd1;
            snap_q      <= snap_d;
            rx_q        <= rx_d;
            hold_q      <= cpu_din;
            src_q       <= src_d;
            pend_q      <= rd_acc;
            full_q      <= full_d;
            prog_done_q <= prog_done_d;
            ovf_q       <= ovf_d;
        end
    end

    assign io_buffer_full = full_q;
    assign prog_done      = prog_done_q;
    assign tx_overflow    = ovf_q;

endmodule

// File: tb/tb_mmio_bridge.sv
// Self-checking bench for mmio_bridge: directed scenarios plus a randomized
// phase, all compared against a behavioural model of the bridge.
module tb_mmio_bridge;

    localparam int DEPTH  = 16;
    localparam int MARGIN = 2;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b0;
    logic [31:0] cpu_a = '0;
    logic [7:0]  cpu_dout = '0;
    logic        cpu_wr = 1'b0;
    logic [7:0]  cpu_din;
    logic        io_buffer_full;
    logic [16:0] ram_a;
    logic [7:0]  ram_dout;
    logic        ram_we;
    logic [7:0]  ram_din = '0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_pop;
    logic        prog_done;
    logic        tx_overflow;

    mmio_bridge #(
        .RAM_ADDR_W  (17),
        .TX_DEPTH    (DEPTH),
        .FULL_MARGIN (MARGIN)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .cpu_a          (cpu_a),
        .cpu_dout       (cpu_dout),
        .cpu_wr         (cpu_wr),
        .cpu_din        (cpu_din),
        .io_buffer_full (io_buffer_full),
        .ram_a          (ram_a),
        .ram_dout       (ram_dout),
        .ram_we         (ram_we),
        .ram_din        (ram_din),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_pop         (rx_pop),
        .prog_done      (prog_done),
        .tx_overflow    (tx_overflow)
    );

    // ---------------- clock ----------------
    always #5 clk_in = ~clk_in;

    // ---------------- RAM endpoint: read data one cycle after address ----
    logic [7:0] ram_mem [0:131071];
    initial for (int i = 0; i < 131072; i++) ram_mem[i] = 8'h00;
    always @(posedge clk_in) begin
        if (ram_we) ram_mem[ram_a] <= ram_dout;
        ram_din <= ram_mem[ram_a];
    end

    // ---------------- scoreboard / model state ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  seen_q[$];
    logic [7:0]  ref_mem [int];
    int          m_count;
    bit          m_ovf, m_done, m_full;
    logic [7:0]  m_din;
    logic [31:0] m_cyc, m_snap;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // TX consumer: every transferred byte must be the oldest expected one.
    always @(negedge clk_in) begin
        if (!rst_in && tx_valid && tx_ready) begin
            check("tx_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("tx_data", tx_data, exp_q.pop_front());
            seen_q.push_back(tx_data);
        end
    end

    // Reset for two cycles with a RAM write presented, checking reset outputs.
    task automatic do_reset();
        rst_in   = 1'b1;
        rdy_in   = 1'b1;
        cpu_wr   = 1'b1;
        cpu_a    = 32'h0000_0010;
        cpu_dout = 8'hEE;
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        @(posedge clk_in);
        @(posedge clk_in);
        #1;
        check("rst_ram_we", ram_we, 1'b0);
        check("rst_cpu_din", cpu_din, 8'h00);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_io_full", io_buffer_full, 1'b0);
        check("rst_prog_done", prog_done, 1'b0);
        check("rst_tx_ovf", tx_overflow, 1'b0);
        rdy_in   = 1'b0;
        cpu_wr   = 1'b0;
        cpu_dout = 8'h00;
        rst_in   = 1'b0;
        exp_q.delete();
        m_count = 0; m_ovf = 0; m_done = 0; m_full = 0;
        m_din = 8'h00; m_cyc = 0; m_snap = 0;
    endtask

    // One bus cycle: drive, check combinational outputs, update model,
    // clock, check registered outputs.
    task automatic cycle(input bit rdy, input bit wr, input logic [31:0] a,
                         input logic [7:0] d, input bit trdy,
                         input bit rxv, input logic [7:0] rxd);
        logic [17:0] a18;
        bit          io, pop_now, push;
        logic [7:0]  pdata;
        int          ridx;
        rdy_in = rdy; cpu_wr = wr; cpu_a = a; cpu_dout = d;
        tx_ready = trdy; rx_valid = rxv; rx_data = rxd;
        a18  = a[17:0];
        io   = (a18 >= 18'h30000);
        ridx = int'(a[16:0]);
        #1;
        check("ram_we", ram_we, rdy && wr && !io);
        check("rx_pop", rx_pop, rdy && !wr && a18 == 18'h30000 && rxv);
        pop_now = trdy && (m_count > 0);
        push    = 0;
        pdata   = 8'h00;
        if (rdy && wr) begin
            if (!io) ref_mem[ridx] = d;
            else if (a18 == 18'h30000 && d != 8'h00) begin push = 1; pdata = d; end
            else if (a18 == 18'h30004) begin push = 1; m_done = 1; end
        end
        if (rdy && !wr) begin
            if (!io) m_din = ref_mem.exists(ridx) ? ref_mem[ridx] : 8'h00;
            else if (a18 == 18'h30000) m_din = rxv ? rxd : 8'h00;
            else if (a18 == 18'h30004) begin m_snap = m_cyc; m_din = m_cyc[7:0]; end
            else if (a18 == 18'h30005) m_din = m_snap[15:8];
            else if (a18 == 18'h30006) m_din = m_snap[23:16];
            else if (a18 == 18'h30007) m_din = m_snap[31:24];
            else m_din = 8'h00;
        end
        if (push) begin
            if (m_count < DEPTH || pop_now) begin
                exp_q.push_back(pdata);
                m_count++;
            end else begin
                m_ovf = 1;
            end
        end
        if (pop_now) m_count--;
        m_full = (DEPTH - m_count) <= MARGIN;
        @(posedge clk_in);
        m_cyc++;
        #1;
        check("cpu_din", cpu_din, m_din);
        check("tx_valid", tx_valid, m_count > 0);
        check("io_buffer_full", io_buffer_full, m_full);
        check("tx_overflow", tx_overflow, m_ovf);
        check("prog_done", prog_done, m_done);
    endtask

    task automatic idle(input int n, input bit trdy);
        for (int i = 0; i < n; i++) cycle(0, 0, 32'h0, 8'h00, trdy, 0, 8'h00);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    // ---------------- main sequence ----------------
    logic [17:0] addr_tab [12];
    initial begin
        logic [31:0] hi;
        logic [31:0] a;
        logic [7:0]  d;
        addr_tab = '{18'h00010, 18'h00011, 18'h1FFFF, 18'h20010, 18'h0ABCD, 18'h30000,
                     18'h30004, 18'h30005, 18'h30006, 18'h30007, 18'h30008, 18'h3FFFF};

        do_reset();

        // Zero writes to the UART register are not characters.
        seen_q.delete();
        cycle(1, 1, 32'h30000, 8'h41, 1, 0, 8'h00);
        cycle(1, 1, 32'h30000, 8'h00, 1, 0, 8'h00);
        cycle(1, 1, 32'h30000, 8'h42, 1, 0, 8'h00);
        idle(5, 1);
        check("tx_seq_len", seen_q.size(), 2);
        if (seen_q.size() == 2) begin
            check("tx_seq0", seen_q[0], 8'h41);
            check("tx_seq1", seen_q[1], 8'h42);
        end

        // Fill with consumer stalled: near-full after 14, overflow on 17th.
        for (int i = 1; i <= 17; i++) begin
            cycle(1, 1, 32'h30000, 8'h55, 0, 0, 8'h00);
            if (i == 13) check("full_after_13", io_buffer_full, 1'b0);
            if (i == 14) check("full_after_14", io_buffer_full, 1'b1);
            if (i == 16) check("ovf_after_16", tx_overflow, 1'b0);
            if (i == 17) check("ovf_after_17", tx_overflow, 1'b1);
        end
        idle(20, 1);
        check("drain_after_fill", exp_q.size(), 0);

        // RAM write then read back.
        cycle(1, 1, 32'h00010, 8'hAB, 0, 0, 8'h00);
        cycle(1, 0, 32'h00010, 8'h00, 0, 0, 8'h00);
        check("ram_readback", cpu_din, 8'hAB);
        idle(2, 0);
        check("ram_hold", cpu_din, 8'hAB);

        // UART RX reads.
        cycle(1, 0, 32'h30000, 8'h00, 0, 1, 8'h7E);
        check("rx_byte", cpu_din, 8'h7E);
        cycle(1, 0, 32'h30000, 8'h00, 0, 0, 8'h7E);
        check("rx_empty", cpu_din, 8'h00);

        // Program stop while the core stalls for three cycles.
        for (int i = 0; i < 3; i++) cycle(0, 1, 32'h30004, 8'h00, 0, 0, 8'h00);
        check("stop_not_yet", prog_done, 1'b0);
        cycle(1, 1, 32'h30004, 8'h00, 0, 0, 8'h00);
        idle(3, 0);
        check("stop_sticky", prog_done, 1'b1);
        check("stop_one_entry", tx_valid, 1'b1);
        check("stop_byte", tx_data, 8'h00);
        cycle(0, 0, 32'h0, 8'h00, 1, 0, 8'h00);
        check("stop_single_push", tx_valid, 1'b0);

        // Reset with pending TX bytes discards them and clears flags.
        cycle(1, 1, 32'h30000, 8'h11, 0, 0, 8'h00);
        cycle(1, 1, 32'h30000, 8'h22, 0, 0, 8'h00);
        do_reset();

        // Counter snapshot coherence.
        idle(32'h1233, 0);
        cycle(1, 0, 32'h30004, 8'h00, 0, 0, 8'h00);
        check("cnt_b0", cpu_din, 8'h33);
        cycle(1, 0, 32'h30005, 8'h00, 0, 0, 8'h00);
        check("cnt_b1", cpu_din, 8'h12);
        cycle(1, 0, 32'h30006, 8'h00, 0, 0, 8'h00);
        check("cnt_b2", cpu_din, 8'h00);
        cycle(1, 0, 32'h30007, 8'h00, 0, 0, 8'h00);
        check("cnt_b3", cpu_din, 8'h00);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            hi = $urandom_range(0, 16383);
            a  = {hi[13:0], addr_tab[$urandom_range(0, 11)]};
            d  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a, d,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                  8'($urandom_range(0, 255)));
        end
        idle(40, 1);
        check("final_drain", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
